// File: rtl/riscv_pkg.sv
// Shared constants for the boot-time instruction memory loader.
package riscv_pkg;

   localparam int BYTES_PER_WORD  = 4;
   localparam int IMEM_ADDR_WIDTH = 10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RECV  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/imem_word_packer.sv
// Packs an incoming byte stream little-endian into one 32-bit word.
module imem_word_packer
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        accept,
   input  logic        clear,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0] byte_idx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         byte_idx <= '0;
         word     <= '0;
      end else if (accept) begin
         word[{byte_idx, 3'b000} +: 8] <= byte_data;
         byte_idx                      <= byte_idx + 2'd1;
      end
   end

   // High on the edge that accepts the last byte of a word; the index wraps to 0 there.
   assign word_full = accept && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory while holding the core in reset.
module imem_loader
   import riscv_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH:0]   load_words,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [WIDTH-1:0]      imem_wdata,
   output logic                  core_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [1:0]          state;
   logic [1:0]          next_state;
   logic [ADDR_WIDTH:0] words_q;
   logic [ADDR_WIDTH:0] word_cnt;
   logic [ADDR_WIDTH:0] cnt_inc;
   logic                start_ok;
   logic                accept;
   logic                word_full;
   logic [31:0]         packed_word;

   assign start_ok   = load_start && (load_words != '0) && (load_words <= DEPTH);
   assign byte_ready = (state == ST_RECV);
   assign accept     = byte_valid && byte_ready;
   assign cnt_inc    = word_cnt + 1'b1;

   imem_word_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept),
      .clear     ((state == ST_IDLE) && start_ok),
      .byte_data (byte_data),
      .word      (packed_word),
      .word_full (word_full)
   );

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start_ok) next_state = ST_RECV;
         ST_RECV:  if (word_full) next_state = ST_WRITE;
         ST_WRITE: next_state = (cnt_inc == words_q) ? ST_DONE : ST_RECV;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Status outputs are registered from next_state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         words_q   <= '0;
         word_cnt  <= '0;
         imem_we   <= 1'b0;
         core_hold <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= next_state;
         imem_we   <= (next_state == ST_WRITE);
         core_hold <= (next_state != ST_IDLE);
         busy      <= (next_state == ST_RECV) || (next_state == ST_WRITE);
         done      <= (next_state == ST_DONE);
         err       <= (state == ST_IDLE) && load_start && !start_ok;
         if ((state == ST_IDLE) && start_ok) begin
            words_q  <= load_words;
            word_cnt <= '0;
         end else if (state == ST_WRITE) begin
            word_cnt <= cnt_inc;
         end
      end
   end

   // The packer register holds the completed word untouched through the WRITE cycle.
   assign imem_addr  = word_cnt[ADDR_WIDTH-1:0];
   assign imem_wdata = packed_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic [AW:0]   load_words;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_hold;
   logic          busy;
   logic          done;
   logic          err;

   int n_cmp = 0;
   int n_mis = 0;

   // Monitor state (written only by the monitor; the stimulus reads snapshots).
   int          n_done_seen  = 0;
   int          n_err_seen   = 0;
   int          n_ready_bad  = 0;
   logic [9:0]  wr_addr[$];
   logic [31:0] wr_data[$];

   imem_loader #(.WIDTH(32), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_words (load_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
         if (byte_ready) n_ready_bad++;
      end
      if (done) n_done_seen++;
      if (err)  n_err_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered and left at a negedge; returns just after the edge that accepted the byte.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic start_load(input logic [AW:0] w);
      load_start = 1'b1;
      load_words = w;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!done && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("done_wait", {31'd0, done}, 32'd1);
   endtask

   initial begin
      int done0;
      int err0;
      int gaps[8];
      gaps = '{0, 2, 1, 0, 3, 0, 1, 2};

      rst        = 1'b0;
      load_start = 1'b0;
      load_words = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_imem_we",    {31'd0, imem_we},    32'd0);
      check("rst_imem_addr",  {22'd0, imem_addr},  32'd0);
      check("rst_imem_wdata", imem_wdata,          32'd0);
      check("rst_core_hold",  {31'd0, core_hold},  32'd0);
      check("rst_busy",       {31'd0, busy},       32'd0);
      check("rst_done",       {31'd0, done},       32'd0);
      check("rst_err",        {31'd0, err},        32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single word
      wr_addr.delete(); wr_data.delete();
      start_load(11'd1);
      check("t1_core_hold", {31'd0, core_hold},  32'd1);
      check("t1_busy",      {31'd0, busy},       32'd1);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("t1_we",        {31'd0, imem_we},    32'd1);
      check("t1_addr",      {22'd0, imem_addr},  32'd0);
      check("t1_wdata",     imem_wdata,          32'h0000_0013);
      check("t1_ready_wr",  {31'd0, byte_ready}, 32'd0);
      @(negedge clk);
      check("t1_done",      {31'd0, done},       32'd1);
      check("t1_we_off",    {31'd0, imem_we},    32'd0);
      check("t1_hold_done", {31'd0, core_hold},  32'd1);
      @(negedge clk);
      check("t1_done_off",  {31'd0, done},       32'd0);
      check("t1_hold_rel",  {31'd0, core_hold},  32'd0);
      check("t1_nwrites",   wr_addr.size(),      32'd1);

      // Back-pressure, two words
      wr_addr.delete(); wr_data.delete();
      start_load(11'd2);
      for (int i = 0; i < 8; i++) send_byte(8'(i + 1), gaps[i]);
      wait_done();
      @(negedge clk);
      check("t2_hold_rel",  {31'd0, core_hold},  32'd0);
      check("t2_nwrites",   wr_addr.size(),      32'd2);
      if (wr_addr.size() == 2) begin
         check("t2_addr0",  {22'd0, wr_addr[0]}, 32'd0);
         check("t2_data0",  wr_data[0],          32'h0403_0201);
         check("t2_addr1",  {22'd0, wr_addr[1]}, 32'd1);
         check("t2_data1",  wr_data[1],          32'h0807_0605);
      end
      check("t2_ready_in_write", n_ready_bad,    32'd0);

      // Bounds: rejected counts
      wr_addr.delete(); wr_data.delete();
      err0 = n_err_seen;
      start_load(11'd0);
      check("t3_err_zero",  {31'd0, err},        32'd1);
      check("t3_hold_zero", {31'd0, core_hold},  32'd0);
      @(negedge clk);
      check("t3_err_pulse", {31'd0, err},        32'd0);
      start_load(11'(DEPTH + 1));
      check("t3_err_big",   {31'd0, err},        32'd1);
      check("t3_hold_big",  {31'd0, core_hold},  32'd0);
      check("t3_busy_big",  {31'd0, busy},       32'd0);
      @(negedge clk);
      check("t3_err_count", n_err_seen - err0,   32'd2);
      check("t3_no_writes", wr_addr.size(),      32'd0);

      // Bounds: full DEPTH load
      done0 = n_done_seen;
      start_load(11'(DEPTH));
      check("t3_depth_accepted", {31'd0, core_hold}, 32'd1);
      for (int i = 0; i < DEPTH * 4; i++) send_byte(8'(i), 0);
      check("t3_last_addr",  {22'd0, imem_addr},  32'(DEPTH - 1));
      check("t3_last_data",  imem_wdata,          32'hFFFE_FDFC);
      @(negedge clk);
      check("t3_depth_done", {31'd0, done},       32'd1);
      check("t3_depth_n",    wr_addr.size(),      32'(DEPTH));
      check("t3_first_data", wr_data[0],          32'h0302_0100);
      @(negedge clk);
      check("t3_depth_done_cnt", n_done_seen - done0, 32'd1);

      // Reset mid-load
      wr_addr.delete(); wr_data.delete();
      done0 = n_done_seen;
      start_load(11'd2);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i), 0);
      rst = 1'b0;
      @(negedge clk);
      check("t4_hold",   {31'd0, core_hold},  32'd0);
      check("t4_busy",   {31'd0, busy},       32'd0);
      check("t4_ready",  {31'd0, byte_ready}, 32'd0);
      check("t4_we",     {31'd0, imem_we},    32'd0);
      check("t4_addr",   {22'd0, imem_addr},  32'd0);
      check("t4_wdata",  imem_wdata,          32'd0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("t4_no_done", n_done_seen - done0, 32'd0);
      wr_addr.delete(); wr_data.delete();
      start_load(11'd1);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 1);
      send_byte(8'hCC, 0);
      send_byte(8'hDD, 0);
      check("t4_new_addr",  {22'd0, imem_addr}, 32'd0);
      check("t4_new_wdata", imem_wdata,         32'hDDCC_BBAA);
      wait_done();
      @(negedge clk);

      // Ignored restart during RECV
      wr_addr.delete(); wr_data.delete();
      err0 = n_err_seen;
      start_load(11'd2);
      send_byte(8'h21, 0);
      send_byte(8'h22, 0);
      start_load(11'd1);
      check("t5_no_err",  {31'd0, err},       32'd0);
      check("t5_busy",    {31'd0, busy},      32'd1);
      send_byte(8'h23, 0);
      send_byte(8'h24, 0);
      for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i), 0);
      wait_done();
      @(negedge clk);
      check("t5_nwrites", wr_addr.size(),     32'd2);
      if (wr_addr.size() == 2) begin
         check("t5_data0", wr_data[0],         32'h2423_2221);
         check("t5_addr1", {22'd0, wr_addr[1]}, 32'd1);
         check("t5_data1", wr_data[1],         32'h3433_3231);
      end
      check("t5_err_cnt", n_err_seen - err0,  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
